pattern_tx: RTL and testbench
=============================

# pattern_tx

Serial bit-pattern transmitter: the sending end of the serial `data_in` stream that `sequence_fsm` consumes.
- Accepts a parallel pattern word with a length and a repeat count through a valid/ready load port.
- Shifts the pattern out one bit per clock, MSB-first, and pulses `done` when the frame is finished.
- Keeps running counts of transmitted 1s and adjacent 1-1 pairs so a bench can predict the detector's response.

## Interface
- `WIDTH`, 16: pattern register width in bits.
- `LEN_W`, 5: width of `load_len`; must be at least $clog2(WIDTH+1).
- `REP_W`, 4: width of `load_rep`.
- `clk` in 1: clock. Single clock domain; all logic acts on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `load_valid` in 1: load request.
- `load_ready` out 1: high in IDLE; a load is accepted on an edge where `load_valid && load_ready`.
- `load_data` in WIDTH: pattern; bits [len-1:0] are sent.
- `load_len` in LEN_W: number of bits per repetition. Values above WIDTH are clamped to WIDTH.
- `load_rep` in REP_W: extra repetitions; total repetitions = `load_rep`+1.
- `abort` in 1: cancels the frame in progress.
- `data_out` out 1: serial bit. Forced to 0 whenever `bit_valid` = 0.
- `bit_valid` out 1: `data_out` carries a pattern bit this cycle.
- `busy` out 1: high while a frame is active (SHIFT or GAP).
- `done` out 1: one-cycle pulse when a frame completes.
- `ones_cnt` out LEN_W+REP_W: number of 1 bits sent in the current or most recent frame.
- `pairs_cnt` out LEN_W+REP_W: number of sent 1-bits whose immediately preceding sent bit, in the same frame, was also 1.

## Operation
- States:
  - IDLE: `load_ready`=1.
  - SHIFT: sending pattern bits.
  - GAP: present only with the macro in Configuration.
- Accept in IDLE:
  - Capture data, clamped length and rep into shadow registers.
  - Clear `ones_cnt`, `pairs_cnt` and the previous-bit flag.
  - Go to SHIFT, with bit index = len-1.
  - `load_data` changes after acceptance have no effect.
- SHIFT, each cycle:
  - `data_out` = pattern[idx], `bit_valid`=1.
  - `ones_cnt` += bit.
  - `pairs_cnt` += (bit && prev); then prev = bit.
  - Decrement idx. At idx 0: if reps remain, reload idx = len-1 and decrement the rep counter; otherwise return to IDLE and pulse `done`.
- `load_len`=0 on accept: no bits sent. `done` pulses in the next cycle; counters read 0.
- `abort`:
  - In SHIFT or GAP: next cycle state is IDLE, `bit_valid`=0, no `done` pulse, counters hold their partial values.
  - In IDLE: ignored.
  - If `abort` and `load_valid` are both high in IDLE, the load is accepted.
- Counters hold their values after `done` until the next accept.
- Counter width LEN_W+REP_W is sized for the maximum frame length WIDTH·2^REP_W; the counters never wrap.

## Timing
- All outputs are registered.
- Load accepted at edge N:
  - Bit k of repetition r is valid in cycle N+1+r·len+k (no-gap build).
  - `done` is high in cycle N+1+(rep+1)·len.
  - `busy` is high from cycle N+1 through the last bit.
- `load_ready` is high in the `done` cycle. A back-to-back accept on that edge makes the next frame's first bit appear in the following cycle. The minimum inter-frame idle is one cycle.
- Reset:
  - While `rst`=1, loads are ignored.
  - After the reset edge: state IDLE, `load_ready`=1.
  - `data_out`, `bit_valid`, `busy`, `done`, `ones_cnt` and `pairs_cnt` are all 0.
- Reset mid-frame: the frame is dropped with no `done` pulse, and outputs take their reset values on the next cycle.
- Priority: `rst` > `abort` > normal shifting.

## Configuration
- `PATTERN_TX_GAP_EN` defined:
  - Between repetitions, one GAP cycle is inserted with `bit_valid`=0 and `data_out`=0.
  - GAP clears the previous-bit flag, so 1-1 pairs are never counted across repetitions.
  - `done` is high in cycle N+1+(rep+1)·len+rep.
- `PATTERN_TX_GAP_EN` undefined:
  - No GAP state; repetitions are contiguous.
  - Pairs spanning a repetition boundary are counted.

## Test plan
- Reset, then load data=16'h0005, len=3, rep=2, no gap.
  - Stream 1,0,1,1,0,1,1,0,1 in cycles N+1..N+9; `done` at N+10.
  - `ones_cnt`=6, `pairs_cnt`=2.
- Same load with `PATTERN_TX_GAP_EN`.
  - Stream 101, gap, 101, gap, 101; `bit_valid` low at N+4 and N+8.
  - `done` at N+12; `ones_cnt`=6, `pairs_cnt`=0.
- Load len=0, then len=20 with WIDTH=16.
  - len=0: `done` one cycle after accept, no `bit_valid`, counters 0.
  - len=20: exactly 16 bits sent.
- Load data=16'hFFFF, len=16, rep=15.
  - 256 ones; `ones_cnt`=256; `pairs_cnt`=255 (no gap) or 240 (gap).
- Assert `abort` after 2 bits of a 3×3 frame.
  - `bit_valid` low the next cycle, no `done`.
  - Counters hold their partial values; `load_ready`=1.
  - A load issued in the same cycle as `abort`, while in IDLE, is accepted.
- Back-to-back loads, with `load_valid` held high across the `done` cycle.
  - The second frame's first bit appears one cycle after `done`.
- Assert `rst` mid-frame.
  - All outputs return to reset values next cycle; no `done` pulse.

Source files
------------

// File: rtl/pattern_tx.sv
`default_nettype none
// ============================================================================
// Module   : pattern_tx
// Purpose  : Serial bit-pattern transmitter. A pattern word, a length and a
//            repeat count are loaded through a valid/ready port, then shifted
//            out MSB-first one bit per clock. Running counts of transmitted
//            ones and of adjacent 1-1 pairs are kept for the current frame.
//
// Ports    : clk, rst        - clock, synchronous active-high reset
//            load_valid      - load request
//            load_ready      - high while idle; load accepted on valid&&ready
//            load_data       - pattern word, bits [len-1:0] are sent
//            load_len        - bits per repetition (clamped to WIDTH)
//            load_rep        - extra repetitions (total = load_rep + 1)
//            abort           - cancels the frame in progress
//            data_out        - serial bit (0 whenever bit_valid is 0)
//            bit_valid       - data_out carries a pattern bit
//            busy            - frame active (SHIFT or GAP)
//            done            - one-cycle pulse at frame completion
//            ones_cnt        - ones sent in current / most recent frame
//            pairs_cnt       - ones whose preceding sent bit was also a one
//
// Options  : PATTERN_TX_GAP_EN - when defined, one idle GAP cycle is inserted
//            between repetitions and it breaks 1-1 pair counting.
//
// Revision : 1.0 - initial release
// ============================================================================
module pattern_tx #(
    parameter int WIDTH = 16,
    parameter int LEN_W = 5,
    parameter int REP_W = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load_valid,
    output logic                   load_ready,
    input  logic [WIDTH-1:0]       load_data,
    input  logic [LEN_W-1:0]       load_len,
    input  logic [REP_W-1:0]       load_rep,
    input  logic                   abort,
    output logic                   data_out,
    output logic                   bit_valid,
    output logic                   busy,
    output logic                   done,
    output logic [LEN_W+REP_W-1:0] ones_cnt,
    output logic [LEN_W+REP_W-1:0] pairs_cnt
);

    // Bit index only has to address WIDTH positions.
    localparam int c_IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int c_CNT_W = LEN_W + REP_W;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_SHIFT = 2'd1;
    localparam logic [1:0] c_ST_GAP   = 2'd2;

    // State entered when a repetition ends and more repetitions remain.
`ifdef PATTERN_TX_GAP_EN
    localparam logic [1:0] c_ST_REP_NEXT = c_ST_GAP;
`else
    localparam logic [1:0] c_ST_REP_NEXT = c_ST_SHIFT;
`endif

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [1:0]         r_state;
    logic [WIDTH-1:0]   r_data;       // shadow copy of the pattern
    logic [c_IDX_W-1:0] r_len_m1;     // len-1, reload value of the index
    logic [c_IDX_W-1:0] r_idx;        // index of the bit currently on data_out
    logic [REP_W-1:0]   r_rep_left;   // repetitions still to start
    logic               r_prev;       // previous sent bit, for pair counting
    logic [c_CNT_W-1:0] r_ones;
    logic [c_CNT_W-1:0] r_pairs;
    logic               r_data_out;
    logic               r_bit_valid;
    logic               r_busy;
    logic               r_done;
    logic               r_load_ready;

    // ------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------
    logic [1:0]         w_state_nxt;
    logic [LEN_W-1:0]   w_len_clamp;
    logic [c_IDX_W-1:0] w_len_m1_idx;
    logic [c_IDX_W-1:0] w_idx_dec;
    logic               w_accept;
    logic               w_shift_nxt;  // a pattern bit is presented next cycle
    logic               w_bit_nxt;    // that bit's value
    logic               w_prev_clr;   // entering a gap: forget previous bit
    logic               w_done_nxt;
    logic [c_IDX_W-1:0] w_idx_nxt;
    logic [REP_W-1:0]   w_rep_nxt;

    assign w_len_clamp  = (load_len > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : load_len;
    // For len==0 this wraps; the value is then never used to fetch a bit.
    assign w_len_m1_idx = c_IDX_W'(w_len_clamp - LEN_W'(1));
    assign w_idx_dec    = r_idx - 1'b1;
    assign w_accept     = (r_state == c_ST_IDLE) && load_valid;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                // A zero-length load finishes without leaving IDLE.
                if (load_valid && (w_len_clamp != '0)) begin
                    w_state_nxt = c_ST_SHIFT;
                end
            end
            c_ST_SHIFT: begin
                if (abort) begin
                    w_state_nxt = c_ST_IDLE;
                end else if (r_idx == '0) begin
                    if (r_rep_left != '0) begin
                        w_state_nxt = c_ST_REP_NEXT;
                    end else begin
                        w_state_nxt = c_ST_IDLE;
                    end
                end
            end
            c_ST_GAP: begin
                w_state_nxt = abort ? c_ST_IDLE : c_ST_SHIFT;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: output / datapath decode. Every output is registered, so this
    // block works out what the outputs must show in the *next* cycle.
    // ------------------------------------------------------------------
    always_comb begin
        w_shift_nxt = 1'b0;
        w_bit_nxt   = 1'b0;
        w_prev_clr  = 1'b0;
        w_done_nxt  = 1'b0;
        w_idx_nxt   = r_idx;
        w_rep_nxt   = r_rep_left;
        case (r_state)
            c_ST_IDLE: begin
                if (load_valid) begin
                    w_idx_nxt = w_len_m1_idx;
                    w_rep_nxt = load_rep;
                    if (w_len_clamp != '0) begin
                        w_shift_nxt = 1'b1;
                        w_bit_nxt   = load_data[w_len_m1_idx];
                    end else begin
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            c_ST_SHIFT: begin
                if (!abort) begin
                    if (r_idx != '0) begin
                        w_idx_nxt   = w_idx_dec;
                        w_shift_nxt = 1'b1;
                        w_bit_nxt   = r_data[w_idx_dec];
                    end else if (r_rep_left != '0) begin
`ifdef PATTERN_TX_GAP_EN
                        // Repetition reload happens on leaving GAP.
                        w_prev_clr  = 1'b1;
`else
                        w_idx_nxt   = r_len_m1;
                        w_rep_nxt   = r_rep_left - 1'b1;
                        w_shift_nxt = 1'b1;
                        w_bit_nxt   = r_data[r_len_m1];
`endif
                    end else begin
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            c_ST_GAP: begin
                if (!abort) begin
                    w_idx_nxt   = r_len_m1;
                    w_rep_nxt   = r_rep_left - 1'b1;
                    w_shift_nxt = 1'b1;
                    w_bit_nxt   = r_data[r_len_m1];
                end
            end
            default: begin
                w_shift_nxt = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Shadow registers, counters and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data       <= '0;
            r_len_m1     <= '0;
            r_idx        <= '0;
            r_rep_left   <= '0;
            r_prev       <= 1'b0;
            r_ones       <= '0;
            r_pairs      <= '0;
            r_data_out   <= 1'b0;
            r_bit_valid  <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_load_ready <= 1'b1;
        end else begin
            r_idx        <= w_idx_nxt;
            r_rep_left   <= w_rep_nxt;
            r_data_out   <= w_shift_nxt & w_bit_nxt;
            r_bit_valid  <= w_shift_nxt;
            r_busy       <= (w_state_nxt != c_ST_IDLE);
            r_load_ready <= (w_state_nxt == c_ST_IDLE);
            r_done       <= w_done_nxt;

            if (w_accept) begin
                r_data   <= load_data;
                r_len_m1 <= w_len_m1_idx;
            end

            // Counters include the bit being presented next cycle, so
            // they always describe every bit already put on data_out.
            if (w_accept) begin
                r_ones  <= c_CNT_W'(w_bit_nxt);
                r_pairs <= '0;
                r_prev  <= w_bit_nxt;
            end else if (w_shift_nxt) begin
                r_ones  <= r_ones + c_CNT_W'(w_bit_nxt);
                r_pairs <= r_pairs + c_CNT_W'(w_bit_nxt & r_prev);
                r_prev  <= w_bit_nxt;
            end else if (w_prev_clr) begin
                r_prev  <= 1'b0;
            end
        end
    end

    assign load_ready = r_load_ready;
    assign data_out   = r_data_out;
    assign bit_valid  = r_bit_valid;
    assign busy       = r_busy;
    assign done       = r_done;
    assign ones_cnt   = r_ones;
    assign pairs_cnt  = r_pairs;

endmodule
`default_nettype wire

// File: tb/tb_pattern_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_pattern_tx
// Purpose  : Self-checking bench for pattern_tx. Each frame's expected
//            per-cycle stream and final counts are built from the frame
//            parameters (clamped length, repetitions, optional gap) and
//            compared cycle by cycle against the transmitter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pattern_tx;

    localparam int WIDTH = 16;
    localparam int LEN_W = 5;
    localparam int REP_W = 4;
    localparam int CW    = LEN_W + REP_W;

`ifdef PATTERN_TX_GAP_EN
    localparam bit c_GAP = 1'b1;
`else
    localparam bit c_GAP = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] load_data;
    logic [LEN_W-1:0] load_len;
    logic [REP_W-1:0] load_rep;
    logic             abort;
    logic             data_out;
    logic             bit_valid;
    logic             busy;
    logic             done;
    logic [CW-1:0]    ones_cnt;
    logic [CW-1:0]    pairs_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    pattern_tx #(.WIDTH(WIDTH), .LEN_W(LEN_W), .REP_W(REP_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .load_len   (load_len),
        .load_rep   (load_rep),
        .abort      (abort),
        .data_out   (data_out),
        .bit_valid  (bit_valid),
        .busy       (busy),
        .done       (done),
        .ones_cnt   (ones_cnt),
        .pairs_cnt  (pairs_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a load and let it be accepted; returns in the first cycle
    // after the accepting edge with the load port scrambled but invalid.
    task automatic do_accept(input logic [WIDTH-1:0] d, input int len,
                             input int rep, input bit abrt);
        n_cmp++;
        if (load_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL accept_ready: load_ready=%b want 1", load_ready);
        end
        load_valid = 1'b1;
        load_data  = d;
        load_len   = LEN_W'(len);
        load_rep   = REP_W'(rep);
        abort      = abrt;
        tick();
        load_valid = 1'b0;
        abort      = 1'b0;
        load_data  = WIDTH'($urandom);
        load_len   = LEN_W'($urandom);
        load_rep   = REP_W'($urandom);
    endtask

    // Called in cycle N+1; checks every frame cycle and returns in the
    // done cycle without advancing past it.
    task automatic check_frame(input logic [WIDTH-1:0] d, input int len,
                               input int rep, input string tag);
        int n;
        int ones;
        int pairs;
        bit prev;
        bit b;
        bit q_v[$];
        bit q_d[$];
        n     = (len > WIDTH) ? WIDTH : len;
        ones  = 0;
        pairs = 0;
        prev  = 1'b0;
        for (int r = 0; r <= rep; r++) begin
            if (c_GAP && r > 0 && n > 0) begin
                q_v.push_back(1'b0);
                q_d.push_back(1'b0);
                prev = 1'b0;
            end
            for (int k = 0; k < n; k++) begin
                b = d[n-1-k];
                q_v.push_back(1'b1);
                q_d.push_back(b);
                if (b) ones++;
                if (b && prev) pairs++;
                prev = b;
            end
        end
        for (int i = 0; i < q_v.size(); i++) begin
            n_cmp++;
            if (bit_valid !== q_v[i] || data_out !== q_d[i] || busy !== 1'b1 ||
                done !== 1'b0 || load_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL %s cycle %0d: got v=%b d=%b busy=%b done=%b rdy=%b, want v=%b d=%b busy=1 done=0 rdy=0",
                         tag, i, bit_valid, data_out, busy, done, load_ready, q_v[i], q_d[i]);
            end
            tick();
        end
        n_cmp++;
        if (done !== 1'b1 || bit_valid !== 1'b0 || data_out !== 1'b0 ||
            busy !== 1'b0 || load_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL %s done_cycle: got done=%b v=%b d=%b busy=%b rdy=%b, want 1 0 0 0 1",
                     tag, done, bit_valid, data_out, busy, load_ready);
        end
        n_cmp++;
        if (ones_cnt !== CW'(ones) || pairs_cnt !== CW'(pairs)) begin
            n_bad++;
            $display("FAIL %s counts: got ones=%0d pairs=%0d, want ones=%0d pairs=%0d",
                     tag, ones_cnt, pairs_cnt, ones, pairs);
        end
    endtask

    task automatic check_idle_reset(input string tag);
        n_cmp++;
        if (data_out !== 1'b0 || bit_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
            ones_cnt !== '0 || pairs_cnt !== '0 || load_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL %s: got d=%b v=%b busy=%b done=%b ones=%0d pairs=%0d rdy=%b, want 0 0 0 0 0 0 1",
                     tag, data_out, bit_valid, busy, done, ones_cnt, pairs_cnt, load_ready);
        end
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        load_valid = 1'b1;
        load_data  = 16'h0005;
        load_len   = 5'd3;
        load_rep   = 4'd0;
        abort      = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        check_idle_reset("reset_state");
        rst        = 1'b0;
        load_valid = 1'b0;
        tick();
        check_idle_reset("load_ignored_in_reset");
    endtask

    task automatic test_basic();
        do_accept(16'h0005, 3, 2, 1'b0);
        check_frame(16'h0005, 3, 2, "basic");
        n_cmp++;
        if (ones_cnt !== CW'(6) || pairs_cnt !== (c_GAP ? CW'(0) : CW'(2))) begin
            n_bad++;
            $display("FAIL basic_const: got ones=%0d pairs=%0d, want 6 %0d",
                     ones_cnt, pairs_cnt, c_GAP ? 0 : 2);
        end
        tick();
        n_cmp++;
        if (done !== 1'b0 || ones_cnt !== CW'(6)) begin
            n_bad++;
            $display("FAIL basic_hold: got done=%b ones=%0d, want 0 6", done, ones_cnt);
        end
    endtask

    task automatic test_len_edges();
        do_accept(16'hBEEF, 0, 3, 1'b0);
        check_frame(16'hBEEF, 0, 3, "len0");
        tick();
        do_accept(16'hA5C3, 20, 0, 1'b0);
        check_frame(16'hA5C3, 20, 0, "len20");
        tick();
    endtask

    task automatic test_full();
        do_accept(16'hFFFF, 16, 15, 1'b0);
        check_frame(16'hFFFF, 16, 15, "full");
        n_cmp++;
        if (ones_cnt !== CW'(256) || pairs_cnt !== (c_GAP ? CW'(240) : CW'(255))) begin
            n_bad++;
            $display("FAIL full_const: got ones=%0d pairs=%0d, want 256 %0d",
                     ones_cnt, pairs_cnt, c_GAP ? 240 : 255);
        end
        tick();
    endtask

    task automatic test_abort();
        // 3x3 frame of 1,1,0; abort during the second bit.
        do_accept(16'h0006, 3, 2, 1'b0);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_cmp++;
        if (bit_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0 || load_ready !== 1'b1 ||
            ones_cnt !== CW'(2) || pairs_cnt !== CW'(1)) begin
            n_bad++;
            $display("FAIL abort: got v=%b done=%b busy=%b rdy=%b ones=%0d pairs=%0d, want 0 0 0 1 2 1",
                     bit_valid, done, busy, load_ready, ones_cnt, pairs_cnt);
        end
        tick();
        n_cmp++;
        if (done !== 1'b0 || ones_cnt !== CW'(2) || pairs_cnt !== CW'(1)) begin
            n_bad++;
            $display("FAIL abort_hold: got done=%b ones=%0d pairs=%0d, want 0 2 1",
                     done, ones_cnt, pairs_cnt);
        end
        // Abort together with a load while idle: the load wins.
        do_accept(16'h002D, 6, 1, 1'b1);
        check_frame(16'h002D, 6, 1, "abort_load");
        tick();
    endtask

    task automatic test_back_to_back();
        do_accept(16'h0013, 5, 1, 1'b0);
        load_valid = 1'b1;
        load_data  = 16'h0B00;
        load_len   = 5'd12;
        load_rep   = 4'd1;
        check_frame(16'h0013, 5, 1, "b2b_first");
        tick();
        load_valid = 1'b0;
        load_data  = WIDTH'($urandom);
        check_frame(16'h0B00, 12, 1, "b2b_second");
        tick();
    endtask

    task automatic test_random();
        logic [WIDTH-1:0] d;
        int len;
        int rep;
        for (int i = 0; i < 12; i++) begin
            d   = WIDTH'($urandom);
            len = int'($urandom_range(0, 20));
            rep = int'($urandom_range(0, 3));
            do_accept(d, len, rep, 1'b0);
            check_frame(d, len, rep, $sformatf("rand%0d", i));
            if ($urandom_range(0, 1) == 1) tick();
        end
        tick();
    endtask

    task automatic test_reset_midframe();
        do_accept(16'hFFFF, 16, 3, 1'b0);
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_idle_reset("rst_midframe");
        for (int i = 0; i < 20; i++) begin
            n_cmp++;
            if (done !== 1'b0 || bit_valid !== 1'b0 || busy !== 1'b0) begin
                n_bad++;
                $display("FAIL rst_after_%0d: got done=%b v=%b busy=%b, want 0 0 0",
                         i, done, bit_valid, busy);
            end
            tick();
        end
    endtask

    initial begin
        rst        = 1'b1;
        load_valid = 1'b0;
        load_data  = '0;
        load_len   = '0;
        load_rep   = '0;
        abort      = 1'b0;
        test_reset();
        test_basic();
        test_len_edges();
        test_full();
        test_abort();
        test_back_to_back();
        test_random();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
